// File: rtl/instr_issue_pkg.sv
// Shared definitions for the instruction issue block.
//   INSTR_W        : width of one CPU instruction word
//   instr_t        : one instruction word
//   issue_state_e  : issue FSM state encoding (3-bit)
package instr_issue_pkg;

  localparam int unsigned INSTR_W = 16;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4
  } issue_state_e;

endpackage

// File: rtl/instr_issue_if.sv
// Host/CPU-facing bundle of the instruction issue block.
//   Host side : wr_en, wr_data (enqueue), run (issue enable level)
//   CPU side  : w (CPU idle), in (IR word), load (IR load pulse), s (start pulse)
//   Status    : full, empty, busy, issued_count, overflow, timeout
// master = host/CPU environment, slave = instr_issue.
interface instr_issue_if;
  import instr_issue_pkg::*;

  logic       wr_en;
  instr_t     wr_data;
  logic       run;
  logic       w;
  instr_t     in;
  logic       load;
  logic       s;
  logic       full;
  logic       empty;
  logic       busy;
  logic [7:0] issued_count;
  logic       overflow;
  logic       timeout;

  modport master (
    output wr_en, wr_data, run, w,
    input  in, load, s, full, empty, busy, issued_count, overflow, timeout
  );

  modport slave (
    input  wr_en, wr_data, run, w,
    output in, load, s, full, empty, busy, issued_count, overflow, timeout
  );

endinterface

// File: rtl/instr_issue_fifo.sv
// Instruction FIFO: DEPTH entries of WIDTH bits, head word presented
// combinationally on rd_data.
//   wr_en/wr_data : enqueue; accepted only when not full
//   rd_en         : pop the head; ignored when empty
//   full/empty    : occupancy flags
//   overflow      : sticky, set by a write attempted while full
module instr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             wr_ok;
  logic             rd_ok;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;
  assign rd_data  = mem_q[rd_ptr_q];
  assign wr_ok    = wr_en & ~full;
  assign rd_ok    = rd_en & ~empty;

  // Storage carries no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_ok && !rd_ok)      count_q <= count_q + 1'b1;
      else if (!wr_ok && rd_ok) count_q <= count_q - 1'b1;
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_issue.sv
// Instruction issue engine: buffers host-written instructions and feeds
// them to the CPU one at a time (in/load, then s, then wait for w to fall
// and rise again). Counts completed instructions and flags handshake
// timeouts; FIFO overflow comes from the FIFO.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : instr_issue_if slave (host write, run, CPU handshake, status)
module instr_issue
  import instr_issue_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  instr_issue_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  issue_state_e  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    count_q, count_d;
  logic          timeout_q, timeout_d;
  logic          pop;
  logic          load_c;
  logic          start_c;

  instr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (bus.in),
    .full     (bus.full),
    .empty    (bus.empty),
    .overflow (bus.overflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    pop       = 1'b0;
    load_c    = 1'b0;
    start_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.run && !bus.empty && bus.w && !timeout_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // CPU IR captures the head word at the same edge that pops it.
        load_c  = 1'b1;
        pop     = 1'b1;
        state_d = ST_START;
      end
      ST_START: begin
        start_c = 1'b1;
        timer_d = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!bus.w) begin
          state_d = ST_WAIT_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
          // Compare against TIMEOUT-1 so the flag lands on the edge where
          // the timer reaches TIMEOUT.
          if (timer_q == TW'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (bus.w) begin
          count_d = count_q + 1'b1;
          state_d = (bus.run && !bus.empty) ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.load         = load_c;
  assign bus.s            = start_c;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.issued_count = count_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_instr_issue.sv
module tb_instr_issue;
  import instr_issue_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 15;

  logic clk;
  logic reset;
  instr_issue_if bus();

  instr_issue #(
    .DEPTH   (DEPTH),
    .AW      (3),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO of accepted words; expected order of issue.
  instr_t ref_q[$];
  instr_t issued_q[$];
  int     acc_total  = 0;
  int     load_total = 0;
  int     proto_err  = 0;
  bit     model_ovf  = 0;
  bit     prev_load  = 0;

  // Stub CPU: MOV (0xD) sets R[ir[9:8]]=ir[7:0], busy 2 cycles;
  // ADD (0xA) out = R[ir[9:8]] + R[ir[1:0]]; others random 1..4 cycles.
  bit         cpu_mute = 0;
  instr_t     cpu_ir;
  int         cpu_rem;
  logic [7:0] regs [4];
  logic [15:0] cpu_out;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.w   <= 1'b1;
      cpu_rem <= 0;
      cpu_out <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (bus.load) cpu_ir <= bus.in;
      if (bus.s) begin
        if (!cpu_mute) begin
          bus.w   <= 1'b0;
          cpu_rem <= (cpu_ir[15:12] == 4'hD) ? 1 : int'($urandom_range(0, 3));
        end
      end else if (!bus.w) begin
        if (cpu_rem == 0) begin
          bus.w <= 1'b1;
          if (cpu_ir[15:12] == 4'hD) regs[cpu_ir[9:8]] <= cpu_ir[7:0];
          else if (cpu_ir[15:12] == 4'hA)
            cpu_out <= {8'h00, regs[cpu_ir[9:8]] + regs[cpu_ir[1:0]]};
        end else begin
          cpu_rem <= cpu_rem - 1;
        end
      end
    end
  end

  // Protocol monitor: samples pre-edge values at each rising edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_load = 0;
    end else begin
      if (bus.load) begin
        issued_q.push_back(bus.in);
        load_total++;
      end
      if (bus.load && bus.s) proto_err++;
      if (bus.s && !prev_load) proto_err++;
      if (prev_load && !bus.s) proto_err++;
      prev_load = bus.load;
    end
  end

  // ---------------- stimulus helpers (all start and end at a negedge) ----
  task automatic do_reset();
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ref_q.delete();
    issued_q.delete();
    acc_total = 0;
    load_total = 0;
    proto_err = 0;
    model_ovf = 0;
    @(negedge clk);
  endtask

  task automatic write_word(input instr_t d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    if (acc_total - load_total < int'(DEPTH)) begin
      ref_q.push_back(d);
      acc_total++;
    end else begin
      model_ovf = 1;
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(bus.busy == 1'b0 && (bus.empty || !bus.run)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: idle not reached within %0d cycles (busy=%b empty=%b)",
               name, budget, bus.busy, bus.empty);
    end
  endtask

  task automatic wait_s(input string name, input int budget);
    int n = 0;
    while (bus.s !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: s pulse not seen within %0d cycles", name, budget);
    end
  endtask

  function automatic instr_t rand_word();
    return instr_t'($urandom);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.empty, bus.full, bus.busy, bus.load, bus.s} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags: empty,full,busy,load,s=%b expected 10000",
               {bus.empty, bus.full, bus.busy, bus.load, bus.s});
    end
    checks++;
    if ({bus.issued_count, bus.overflow, bus.timeout} !== 10'd0) begin
      failures++;
      $display("FAIL reset_counters: count=%0d ovf=%b to=%b expected 0 0 0",
               bus.issued_count, bus.overflow, bus.timeout);
    end
    // Asynchronous reset in WAIT_DONE with one instruction already counted.
    for (int i = 0; i < 3; i++) write_word(16'hD000 | instr_t'(i));
    bus.run = 1'b1;
    while (bus.issued_count != 8'd1 && load_total < 10) @(negedge clk);
    wait_s("reset_mid_s", 50);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.issued_count !== 8'd1 || bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL pre_async_reset: busy=%b count=%0d empty=%b expected 1 1 0",
               bus.busy, bus.issued_count, bus.empty);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.load, bus.s, bus.empty, bus.full} !== 5'b00010 ||
        bus.issued_count !== 8'd0) begin
      failures++;
      $display("FAIL async_reset: busy,load,s,empty,full=%b count=%0d expected 00010 0",
               {bus.busy, bus.load, bus.s, bus.empty, bus.full}, bus.issued_count);
    end
    do_reset();
  endtask

  task automatic test_program();
    bit same;
    do_reset();
    write_word(16'hD007);
    write_word(16'hD102);
    write_word(16'hA140);
    bus.run = 1'b1;
    wait_idle("program", 200);
    checks++;
    if (load_total != 3 || proto_err != 0) begin
      failures++;
      $display("FAIL program_pulses: loads=%0d proto_err=%0d expected 3 0",
               load_total, proto_err);
    end
    checks++;
    if (bus.issued_count !== 8'd3 || bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL program_status: count=%0d empty=%b busy=%b expected 3 1 0",
               bus.issued_count, bus.empty, bus.busy);
    end
    same = (issued_q.size() == ref_q.size());
    for (int i = 0; i < issued_q.size() && same; i++) same = (issued_q[i] === ref_q[i]);
    checks++;
    if (!same) begin
      failures++;
      $display("FAIL program_order: %0d words issued, %0d expected or content differs",
               issued_q.size(), ref_q.size());
    end
    checks++;
    if (cpu_out !== 16'h0009) begin
      failures++;
      $display("FAIL program_result: cpu out=%h expected 0009", cpu_out);
    end
    bus.run = 1'b0;
  endtask

  task automatic test_overflow();
    bit same;
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) write_word(rand_word());
    checks++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL fill: full=%b overflow=%b expected 1 0", bus.full, bus.overflow);
    end
    write_word(16'hBEEF);
    checks++;
    if (bus.full !== 1'b1 || bus.overflow !== model_ovf) begin
      failures++;
      $display("FAIL overflow: full=%b overflow=%b expected 1 %b",
               bus.full, bus.overflow, model_ovf);
    end
    bus.run = 1'b1;
    wait_idle("drain", 400);
    same = (issued_q.size() == ref_q.size()) && (ref_q.size() == int'(DEPTH));
    for (int i = 0; i < issued_q.size() && same; i++) same = (issued_q[i] === ref_q[i]);
    checks++;
    if (!same || bus.issued_count !== 8'(DEPTH) || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL drain_order: issued=%0d count=%0d overflow=%b expected %0d words in order, count %0d, overflow 1",
               issued_q.size(), bus.issued_count, bus.overflow, DEPTH, DEPTH);
    end
    bus.run = 1'b0;
  endtask

  task automatic test_run_drop();
    do_reset();
    write_word(rand_word());
    bus.run = 1'b1;
    wait_s("run_drop_s", 50);
    @(negedge clk);
    bus.run = 1'b0;
    write_word(rand_word());
    write_word(rand_word());
    wait_idle("run_drop", 100);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.issued_count !== 8'd1 || bus.busy !== 1'b0 || bus.empty !== 1'b0 ||
        acc_total - load_total != 2) begin
      failures++;
      $display("FAIL run_drop: count=%0d busy=%b empty=%b pending=%0d expected 1 0 0 2",
               bus.issued_count, bus.busy, bus.empty, acc_total - load_total);
    end
    bus.run = 1'b1;
    wait_idle("run_resume", 200);
    checks++;
    if (bus.issued_count !== 8'd3 || bus.empty !== 1'b1 || proto_err != 0) begin
      failures++;
      $display("FAIL run_resume: count=%0d empty=%b proto_err=%0d expected 3 1 0",
               bus.issued_count, bus.empty, proto_err);
    end
    bus.run = 1'b0;
  endtask

  task automatic test_timeout();
    int seen_at;
    int loads_before;
    do_reset();
    cpu_mute = 1;
    write_word(rand_word());
    write_word(rand_word());
    bus.run = 1'b1;
    wait_s("timeout_s", 50);
    seen_at = -1;
    for (int i = 1; i <= int'(TIMEOUT) + 3; i++) begin
      @(negedge clk);
      if (bus.timeout === 1'b1 && seen_at < 0) seen_at = i;
    end
    // WAIT_ACK begins at the edge after the s cycle; the flag should be
    // visible in the cycle that starts TIMEOUT edges later.
    checks++;
    if (seen_at != int'(TIMEOUT) + 1) begin
      failures++;
      $display("FAIL timeout_latency: flag at cycle %0d after s, expected %0d",
               seen_at, TIMEOUT + 1);
    end
    loads_before = load_total;
    repeat (30) @(negedge clk);
    checks++;
    if (load_total != loads_before || bus.busy !== 1'b0 || bus.empty !== 1'b0 ||
        bus.issued_count !== 8'd0) begin
      failures++;
      $display("FAIL timeout_block: new loads=%0d busy=%b empty=%b count=%0d expected 0 0 0 0",
               load_total - loads_before, bus.busy, bus.empty, bus.issued_count);
    end
    cpu_mute = 0;
    do_reset();
    checks++;
    if (bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: timeout=%b expected 0", bus.timeout);
    end
  endtask

  task automatic test_back_to_back();
    bit same;
    int n;
    do_reset();
    for (int i = 0; i < int'(DEPTH) - 1; i++) write_word(rand_word());
    bus.run = 1'b1;
    n = 0;
    while (bus.load !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    write_word(16'h5A5A);
    checks++;
    if (bus.full !== 1'b0 || acc_total - load_total != int'(DEPTH) - 1) begin
      failures++;
      $display("FAIL write_during_pop: full=%b pending=%0d expected 0 %0d",
               bus.full, acc_total - load_total, DEPTH - 1);
    end
    wait_idle("pop_drain", 400);
    do_reset();
    bus.run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      write_word(rand_word());
      wait_idle("pair", 60);
    end
    same = (issued_q.size() == ref_q.size()) && (ref_q.size() == 20);
    for (int i = 0; i < issued_q.size() && same; i++) same = (issued_q[i] === ref_q[i]);
    checks++;
    if (!same || bus.issued_count !== 8'd20 || proto_err != 0) begin
      failures++;
      $display("FAIL wrap_pairs: issued=%0d count=%0d proto_err=%0d expected 20 words in order, count 20, 0",
               issued_q.size(), bus.issued_count, proto_err);
    end
    bus.run = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.run = 1'b0;
    @(negedge clk);
    test_reset();
    test_program();
    test_overflow();
    test_run_drop();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
- Upstream feeder for the CPU datapath/controller.
- Buffers 16-bit instructions written by a host (test harness or later memory stage) in a small FIFO.
- Issues them one at a time using the CPU's existing handshake: drive `in`, pulse `load`, pulse `s`, wait for `w` to fall then rise.
- Counts completed instructions and flags overflow and handshake timeouts.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- AW, 3, log2(DEPTH); FIFO pointer width.
- TIMEOUT, 15, max cycles after `s` for `w` to fall before error; ≥2.

Ports:
- clk  in  1  rising-edge clock, shared with the CPU.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  host write strobe.
- wr_data  in  16  instruction to enqueue.
- run  in  1  level; 1 = issue while instructions are available.
- w  in  1  CPU wait/ready; 1 = CPU idle.
- in  out  16  instruction to the CPU IR; equals the FIFO head.
- load  out  1  CPU IR load enable; one-cycle pulse.
- s  out  1  CPU start; one-cycle pulse.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- busy  out  1  FSM not in IDLE.
- issued_count  out  8  completed instructions, wraps 255→0.
- overflow  out  1  sticky; a write was attempted while full.
- timeout  out  1  sticky; `w` did not fall within TIMEOUT cycles of `s`.

Behaviour:
- Reset (async, active-high), all outputs:
  - load=0, s=0, busy=0, issued_count=0, overflow=0, timeout=0.
  - FIFO pointers and count cleared, so empty=1, full=0.
  - `in` = stale head contents, don't-care while empty.
  - FSM → IDLE.
  - Reset mid-instruction abandons it; the CPU resets separately.
- FIFO:
  - Write accepted iff wr_en & !full.
  - wr_en & full: data dropped, overflow←1.
  - Pop occurs only in LOAD.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - `in` is the combinational head word.
- FSM states: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE.
  - IDLE: go to LOAD when run & !empty & w & !timeout; otherwise stay.
  - LOAD (1 cycle): load=1, pop head; CPU IR captures `in` at this edge. Always go to START.
  - START (1 cycle): s=1; timer←0. Always go to WAIT_ACK.
  - WAIT_ACK: if w==0 go to WAIT_DONE. Otherwise increment timer; when timer reaches TIMEOUT, timeout←1 and go to IDLE (count not incremented).
  - WAIT_DONE: wait for w==1, then issued_count+1.
    - If run & !empty: go to LOAD (back-to-back, no IDLE cycle).
    - Otherwise: go to IDLE.
- Dropping run mid-instruction: the current instruction completes; the FSM then stops in IDLE.
- While timeout=1, no further issue occurs until reset.
- Minimum issue period: 4 cycles + CPU execution time.
  - Example: MOV imm gives `w` low for 2 cycles (Decode, MovImm).
- load and s are never asserted in the same cycle; each is high for exactly one cycle per instruction.

Decomposition:
- Shared package: FSM state encodings (3-bit: IDLE=0, LOAD=1, START=2, WAIT_ACK=3, WAIT_DONE=4) and the instruction-width constant (16).
- Natural sub-module: instr_fifo, parameterised DEPTH/AW/width.
  - Ports: wr_en, wr_data, rd_en, rd_data, full, empty, overflow.
- The FSM and counters live in instr_issue.

Test Plan:
- Reset then idle → empty=1, full=0, busy=0, load=s=0, issued_count=0. Assert reset asynchronously mid-WAIT_DONE → all outputs cleared before the next clk edge.
- Write 16'hD007 (MOV R0,#7), 16'hD102 (MOV R1,#2), 16'hA140 (ADD R2,R1,R0) with run=1, real CPU attached:
  - load pulses exactly 3 times, each followed next cycle by s.
  - issued_count=3, empty=1, busy=0.
  - CPU out=16'h0009 after the third instruction.
- Fill with DEPTH=8 words, then one more write → full=1, overflow=1, 9th word absent; drain yields the 8 words in order.
- run=1, 1 queued; deassert run during WAIT_ACK with 2 more queued → that instruction completes, issued_count=1, FSM IDLE, 2 entries remain; reassert run → count reaches 3.
- Stub CPU holds w=1 after s → timeout=1 exactly TIMEOUT cycles after WAIT_ACK entry; FSM returns to IDLE; no further load with entries queued; reset clears the flag.
- Write during the LOAD pop with count=DEPTH-1 → count unchanged, full stays 0; pointer wrap verified by 20 sequential write/issue pairs (issued_count=20).
